// File: rtl/debug_commit_sequencer.sv
// Debug-port command sequencer: captures request edges per channel and issues
// each pending command as a single-cycle strobe in the CPU COMMIT phase.
module debug_commit_sequencer #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CNT_W  = 4,
  parameter bit          ONEHOT = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             COMMIT,
  input  logic [NCH-1:0]   REQ,
  input  logic [CNT_W-1:0] REPEAT,
  input  logic             CLR_OVR,
  output logic [NCH-1:0]   ISSUE,
  output logic [NCH-1:0]   PENDING,
  output logic             BUSY,
  output logic [NCH-1:0]   OVERRUN
);

  logic [NCH-1:0]   r_req_q;
  logic [NCH-1:0]   r_pending;
  logic [NCH-1:0]   r_overrun;
  logic [CNT_W-1:0] r_cnt [NCH];

  logic [NCH-1:0]   w_edge;
  logic [NCH-1:0]   w_grant;
  logic [NCH-1:0]   w_issue;
  logic [NCH-1:0]   w_final;
  logic             w_found;

  assign w_edge = REQ & ~r_req_q;

  // Grant looks only at registered state so a same-cycle request never issues.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    if (ONEHOT) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (r_pending[i] && !w_found) begin
          w_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end else begin
      w_grant = r_pending;
    end
  end

  assign w_issue = {NCH{COMMIT}} & w_grant;

  always_comb begin
    w_final = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_final[i] = w_issue[i] && (r_cnt[i] == '0);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_req_q   <= '1;
      r_pending <= '0;
      r_overrun <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_req_q <= REQ;
      for (int unsigned i = 0; i < NCH; i++) begin
        // A new edge may reload a channel in the same cycle as its final issue.
        if (w_edge[i] && (!r_pending[i] || w_final[i])) begin
          r_pending[i] <= 1'b1;
          r_cnt[i]     <= REPEAT;
        end else if (w_issue[i]) begin
          if (w_final[i]) begin
            r_pending[i] <= 1'b0;
          end else begin
            r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          end
        end

        if (w_edge[i] && r_pending[i] && !w_final[i]) begin
          r_overrun[i] <= 1'b1;
        end else if (CLR_OVR) begin
          r_overrun[i] <= 1'b0;
        end
      end
    end
  end

  assign ISSUE   = w_issue;
  assign PENDING = r_pending;
  assign BUSY    = |r_pending;
  assign OVERRUN = r_overrun;

endmodule

// File: tb/tb_debug_commit_sequencer.sv
// Bench for debug_commit_sequencer: directed scenarios plus randomized traffic
// checked against a remaining-issue-count model, for both arbitration modes.
module tb_debug_commit_sequencer;

  localparam int NCH   = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             commit;
  logic [NCH-1:0]   req;
  logic [CNT_W-1:0] rep;
  logic             clr;

  logic [NCH-1:0]   issue1, pend1, ovr1;
  logic [NCH-1:0]   issue0, pend0, ovr0;
  logic             busy1, busy0;

  int n_pass  = 0;
  int n_total = 0;
  int phase   = 0;

  always #5 clk = ~clk;

  debug_commit_sequencer #(.NCH(NCH), .CNT_W(CNT_W), .ONEHOT(1'b1)) dut (
    .CLK(clk), .RESET_N(rst_n), .COMMIT(commit), .REQ(req), .REPEAT(rep),
    .CLR_OVR(clr), .ISSUE(issue1), .PENDING(pend1), .BUSY(busy1), .OVERRUN(ovr1)
  );

  debug_commit_sequencer #(.NCH(NCH), .CNT_W(CNT_W), .ONEHOT(1'b0)) dut_all (
    .CLK(clk), .RESET_N(rst_n), .COMMIT(commit), .REQ(req), .REPEAT(rep),
    .CLR_OVR(clr), .ISSUE(issue0), .PENDING(pend0), .BUSY(busy0), .OVERRUN(ovr0)
  );

  // Reference model: each channel holds the number of issues still owed.
  int           rem1 [NCH];
  int           rem0 [NCH];
  bit           mov1 [NCH];
  bit           mov0 [NCH];
  logic [NCH-1:0] reqp;

  function automatic logic [NCH-1:0] m_issue(input bit oh);
    logic [NCH-1:0] r;
    r = '0;
    if (commit) begin
      for (int i = 0; i < NCH; i++) begin
        if (oh) begin
          if (rem1[i] > 0 && r == '0) r[i] = 1'b1;
        end else begin
          if (rem0[i] > 0) r[i] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_pend(input bit oh);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i] = oh ? (rem1[i] > 0) : (rem0[i] > 0);
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_ovr(input bit oh);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i] = oh ? mov1[i] : mov0[i];
    return r;
  endfunction

  function automatic int nrem(input int r, input bit iss, input bit e, input int rp);
    int a;
    a = iss ? r - 1 : r;
    if (e && a == 0) return rp + 1;
    return a;
  endfunction

  function automatic bit novr(input int r, input bit iss, input bit e, input bit ov, input bit c);
    int a;
    a = iss ? r - 1 : r;
    if (e && a != 0) return 1'b1;
    if (c) return 1'b0;
    return ov;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        rem1[i] <= 0; rem0[i] <= 0; mov1[i] <= 1'b0; mov0[i] <= 1'b0;
      end
      reqp <= '1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        rem1[i] <= nrem(rem1[i], m_issue(1'b1) >> i & 1, req[i] & ~reqp[i], int'(rep));
        rem0[i] <= nrem(rem0[i], m_issue(1'b0) >> i & 1, req[i] & ~reqp[i], int'(rep));
        mov1[i] <= novr(rem1[i], m_issue(1'b1) >> i & 1, req[i] & ~reqp[i], mov1[i], clr);
        mov0[i] <= novr(rem0[i], m_issue(1'b0) >> i & 1, req[i] & ~reqp[i], mov0[i], clr);
      end
      reqp <= req;
    end
  end

  // Advance one cycle: returns just after the falling edge with COMMIT updated.
  task automatic tick();
    @(negedge clk);
    commit = (phase == 3);
    phase  = (phase + 1) % 4;
  endtask

  task automatic align(input int ph);
    for (int k = 0; k < 4 && phase != ph; k++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; commit = 1'b0; req = '0; rep = '0; clr = 1'b0;
    repeat (3) tick();
    #1;
    n_total++;
    if (pend1 !== '0 || issue1 !== '0 || ovr1 !== '0 || busy1 !== 1'b0) begin
      $display("FAIL reset_state pend=%b issue=%b ovr=%b busy=%b want all 0", pend1, issue1, ovr1, busy1);
    end else n_pass++;
    tick(); rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_single();
    align(3);
    tick(); req = 4'b0001; rep = '0;
    #1;
    n_total++;
    if (issue1 !== 4'b0000) $display("FAIL single_same_cycle issue=%b want 0000", issue1);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      n_total++;
      if (issue1 !== 4'b0000 || pend1 !== 4'b0001)
        $display("FAIL single_wait k=%0d issue=%b pend=%b want 0000/0001", k, issue1, pend1);
      else n_pass++;
    end
    tick(); #1;
    n_total++;
    if (issue1 !== 4'b0001) $display("FAIL single_issue issue=%b want 0001", issue1);
    else n_pass++;
    tick(); #1;
    n_total++;
    if (pend1 !== 4'b0000) $display("FAIL single_pend_clear pend=%b want 0000", pend1);
    else n_pass++;
    tick(); tick(); tick(); #1;
    n_total++;
    if (commit !== 1'b1 || issue1 !== 4'b0000)
      $display("FAIL single_no_reissue commit=%b issue=%b want 1/0000", commit, issue1);
    else n_pass++;
  endtask

  task automatic test_repeat();
    int c;
    c = 0;
    tick(); req = 4'b0000;
    tick(); req = 4'b0100; rep = 4'd3;
    for (int k = 0; k < 24; k++) begin
      tick(); #1;
      if (commit) begin
        n_total++;
        if (issue1[2] !== (c < 4)) $display("FAIL repeat_commit%0d issue=%b want bit2=%0d", c, issue1, c < 4);
        else n_pass++;
        c++;
      end
    end
    n_total++;
    if (pend1[2] !== 1'b0 || busy1 !== 1'b0) $display("FAIL repeat_done pend=%b busy=%b want 0", pend1, busy1);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    int c;
    c = 0;
    tick(); req = 4'b0000; rep = '0;
    align(0);
    tick(); req = 4'b1010;
    for (int k = 0; k < 12; k++) begin
      tick(); #1;
      if (commit && c < 2) begin
        n_total++;
        if (issue1 !== (c == 0 ? 4'b0010 : 4'b1000))
          $display("FAIL arb_onehot_commit%0d issue=%b want %b", c, issue1, c == 0 ? 4'b0010 : 4'b1000);
        else n_pass++;
        n_total++;
        if (issue0 !== (c == 0 ? 4'b1010 : 4'b0000))
          $display("FAIL arb_all_commit%0d issue=%b want %b", c, issue0, c == 0 ? 4'b1010 : 4'b0000);
        else n_pass++;
        c++;
      end
    end
  endtask

  task automatic test_overrun();
    int n;
    n = 0;
    tick(); req = 4'b0000;
    align(0);
    tick(); req = 4'b0010; rep = 4'd2;
    tick(); req = 4'b0000;
    tick(); req = 4'b0010; rep = 4'd7;
    for (int k = 0; k < 20; k++) begin
      tick(); #1;
      if (k == 0) begin
        n_total++;
        if (ovr1 !== 4'b0010) $display("FAIL overrun_flag ovr=%b want 0010", ovr1);
        else n_pass++;
      end
      if (issue1[1] === 1'b1) n++;
    end
    n_total++;
    if (n != 3) $display("FAIL overrun_issue_count got %0d want 3", n);
    else n_pass++;
    tick(); clr = 1'b1;
    tick(); clr = 1'b0; #1;
    n_total++;
    if (ovr1 !== 4'b0000) $display("FAIL overrun_clear ovr=%b want 0000", ovr1);
    else n_pass++;
    // Re-request landing exactly on the final issue reloads cleanly.
    tick(); req = 4'b0000;
    align(0);
    tick(); req = 4'b0010; rep = 4'd0;
    tick(); req = 4'b0000;
    tick();
    tick(); req = 4'b0010; rep = 4'd1; #1;
    n_total++;
    if (issue1 !== 4'b0010) $display("FAIL reload_final_issue issue=%b want 0010", issue1);
    else n_pass++;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick(); #1;
      if (issue1[1] === 1'b1) n++;
    end
    n_total++;
    if (n != 2 || ovr1 !== 4'b0000) $display("FAIL reload_count got %0d ovr=%b want 2/0000", n, ovr1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    tick(); req = 4'b0000;
    align(0);
    tick(); req = 4'b0001; rep = 4'd5;
    for (int k = 0; k < 20 && n < 2; k++) begin
      tick(); #1;
      if (issue1[0] === 1'b1) n++;
    end
    n_total++;
    if (n != 2) $display("FAIL reset_mid_setup issues=%0d want 2", n);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (pend1 !== '0 || issue1 !== '0 || ovr1 !== '0 || busy1 !== 1'b0)
      $display("FAIL reset_mid_clear pend=%b issue=%b ovr=%b busy=%b want all 0", pend1, issue1, ovr1, busy1);
    else n_pass++;
    tick(); tick(); rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick(); #1;
      if (issue1 !== 4'b0000) n++;
    end
    n_total++;
    if (n != 0 || pend1 !== 4'b0000) $display("FAIL reset_release_held issues=%0d pend=%b want 0/0000", n, pend1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NCH-1:0] flip;
    for (int k = 0; k < 400; k++) begin
      tick();
      flip = '0;
      for (int i = 0; i < NCH; i++) flip[i] = ($urandom_range(0, 3) == 0);
      req = req ^ flip;
      rep = CNT_W'($urandom_range(0, 3));
      clr = ($urandom_range(0, 15) == 0);
      #1;
      n_total++;
      if (issue1 !== m_issue(1'b1) || pend1 !== m_pend(1'b1) || ovr1 !== m_ovr(1'b1) || busy1 !== (|m_pend(1'b1)))
        $display("FAIL rand_onehot k=%0d issue=%b pend=%b ovr=%b busy=%b want %b %b %b %b", k,
                 issue1, pend1, ovr1, busy1, m_issue(1'b1), m_pend(1'b1), m_ovr(1'b1), |m_pend(1'b1));
      else n_pass++;
      n_total++;
      if (issue0 !== m_issue(1'b0) || pend0 !== m_pend(1'b0) || ovr0 !== m_ovr(1'b0) || busy0 !== (|m_pend(1'b0)))
        $display("FAIL rand_all k=%0d issue=%b pend=%b ovr=%b busy=%b want %b %b %b %b", k,
                 issue0, pend0, ovr0, busy0, m_issue(1'b0), m_pend(1'b0), m_ovr(1'b0), |m_pend(1'b0));
      else n_pass++;
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_arbitration();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
